datapath_rr_scheduler: RTL
==========================

// Module: datapath_rr_scheduler
// PURPOSE
// Shares one instance of the N-bit arithmetic datapath (A, B, opcode -> Y, co)
// between NREQ requesters. Round-robin grant, valid/ready on the request side,
// registered issue into the datapath, and a tag pipeline that matches each result
// to its requester. Sits between client blocks and the datapath instance.
// PARAMETERS
// N     16  operand/result width; must match the datapath instance's N
// NREQ  2   number of requesters, 2..8
// LAT   1   datapath clocks from dp_* inputs to dp_y/dp_co (0 = combinational), 0..7
// PORTS
// clk        in   1       clock, all state on rising edge
// rst_n      in   1       asynchronous, active-low reset
// req_valid  in   NREQ    request pending, one bit per requester
// req_ready  out  NREQ    one-hot grant; transfer = req_valid[i] & req_ready[i]
// req_a      in   NREQ*N  operand A per requester, slice i = [i*N +: N], signed
// req_b      in   NREQ*N  operand B per requester, signed
// req_op     in   NREQ*3  opcode per requester
// halt       in   1       block new grants; in-flight operations drain
// dp_a       out  N       registered operand A to datapath
// dp_b       out  N       registered operand B to datapath
// dp_op      out  3       registered opcode to datapath
// dp_y       in   N       datapath result
// dp_co      in   1       datapath carry-out
// rsp_valid  out  1       result valid this cycle; no backpressure, must be taken
// rsp_id     out  $clog2(NREQ)  requester index owning the result
// rsp_y      out  N       result (= dp_y when rsp_valid)
// rsp_co     out  1       carry (= dp_co when rsp_valid)
// idle       out  1       no operation in flight
// BEHAVIOUR
// - Reset (async, rst_n=0): dp_a/dp_b/dp_op=0, all tags cleared, ptr=0,
//   inflight=0; req_ready=0, rsp_valid=0, rsp_id=0, idle=1. Mid-operation reset
//   discards all in-flight ops; no rsp_valid for them after release.
// - Grant (combinational): if halt=0 and req_valid!=0, req_ready = one-hot of first
//   set req_valid bit searching ptr, ptr+1, ... wrapping at NREQ. Else req_ready=0.
//   halt wins over any req_valid. req_ready may depend on req_valid.
// - On transfer by g at edge t: dp_a/dp_b/dp_op <= req slices of g; stage-0 tag
//   <= {1,g}; ptr <= (g==NREQ-1) ? 0 : g+1. No transfer: dp_* hold, tag valid=0.
// - Throughput one op per cycle; responses in issue order.
// - Tag pipeline LAT+1 stages {valid,id}; stage 0 aligns with dp_* registers.
//   rsp_valid/rsp_id = last stage; result of transfer at edge t appears in the
//   cycle after edge t+LAT (LAT=0: cycle right after transfer edge).
// - rsp_y/rsp_co pass dp_y/dp_co through; forced 0 when rsp_valid=0.
// - inflight counter 0..LAT+1: +1 on transfer, -1 when rsp_valid, both = hold.
//   idle = (inflight==0). Counter never overflows (bounded by pipeline depth).
// - Non-requesting requesters do not advance ptr; single requester gets every cycle.
// - Opcodes are not checked; all 3-bit values forwarded unchanged.
// STRUCTURE
// - Package dp_sched_pkg: OPW=3, typedef logic [OPW-1:0] op_t, tag_t struct
//   {logic valid; logic [2:0] id;}, MAX_NREQ=8, MAX_LAT=7.
// - Sub-module rr_arbiter #(NREQ): req, ptr -> one-hot grant + encoded index.
// - Top holds issue registers, tag shift register, ptr, inflight counter.
// TESTING (datapath instance with pipe matching LAT, default N=16)
// - Reset: rst_n=0 with req_valid=2'b11 -> req_ready=0, rsp_valid=0, dp_a=0, idle=1.
// - Single op: LAT=1, r0 A=5 B=3 op=000 one cycle -> req_ready=01 same cycle, dp_a=5
//   next cycle, rsp_valid=1 rsp_id=0 rsp_y=datapath model(5,3,000) one cycle later.
// - Contention: both valid 8 cycles -> grants 0,1,0,1,...; rsp_id sequence equal.
// - Halt: 3 ops issued then halt=1 with req_valid=11 -> req_ready=0, 3 rsp arrive,
//   idle=1 after last; halt=0 -> grant resumes at ptr.
// - Reset mid-op: 2 in flight, rst_n pulsed -> no rsp_valid after release, idle=1.
// - LAT=0 build: back-to-back r1 ops A=-7 B=2 -> rsp every cycle, 1 cycle after issue.

Source files
------------

// File: rtl/dp_sched_pkg.sv
// Shared types and limits for the round-robin datapath scheduler.
package dp_sched_pkg;
    localparam int OPW      = 3;
    localparam int MAX_NREQ = 8;
    localparam int MAX_LAT  = 7;
    localparam int IDMAX_W  = $clog2(MAX_NREQ);
    localparam int CNT_W    = $clog2(MAX_LAT + 2);

    typedef logic [OPW-1:0] op_t;

    typedef struct packed {
        logic               valid;
        logic [IDMAX_W-1:0] id;
    } tag_t;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first requester at or after ptr, wrapping at NREQ.
module rr_arbiter #(
    parameter  int NREQ = 2,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  idx
);
    logic found;
    int   j;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int i = 0; i < NREQ; i++) begin
            j = int'(ptr) + i;
            if (j >= NREQ) j = j - NREQ;
            if (!found && req[j]) begin
                found  = 1'b1;
                gnt[j] = 1'b1;
                idx    = IDW'(j);
            end
        end
    end
endmodule

// File: rtl/datapath_rr_scheduler.sv
// Shares one arithmetic datapath among NREQ requesters with round-robin issue
// and a tag pipeline that returns each result to its owner.
module datapath_rr_scheduler
    import dp_sched_pkg::*;
#(
    parameter  int N    = 16,
    parameter  int NREQ = 2,
    parameter  int LAT  = 1,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*N-1:0] req_a,
    input  logic [NREQ*N-1:0] req_b,
    input  logic [NREQ*3-1:0] req_op,
    input  logic              halt,
    output logic [N-1:0]      dp_a,
    output logic [N-1:0]      dp_b,
    output logic [2:0]        dp_op,
    input  logic [N-1:0]      dp_y,
    input  logic              dp_co,
    output logic              rsp_valid,
    output logic [IDW-1:0]    rsp_id,
    output logic [N-1:0]      rsp_y,
    output logic              rsp_co,
    output logic              idle
);
    logic [NREQ-1:0]  arb_req;
    logic [NREQ-1:0]  gnt;
    logic [IDW-1:0]   gidx;
    logic [IDW-1:0]   ptr;
    logic             xfer;
    logic [CNT_W-1:0] inflight;
    tag_t             tag_pipe [LAT+1];

    logic [N-1:0] a_arr  [NREQ];
    logic [N-1:0] b_arr  [NREQ];
    op_t          op_arr [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign a_arr[i]  = req_a[i*N +: N];
        assign b_arr[i]  = req_b[i*N +: N];
        assign op_arr[i] = req_op[i*OPW +: OPW];
    end

    // No grants while held in reset or halted; in-flight work still drains.
    assign arb_req = (halt || !rst_n) ? '0 : req_valid;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req (arb_req),
        .ptr (ptr),
        .gnt (gnt),
        .idx (gidx)
    );

    assign req_ready = gnt;
    assign xfer      = |gnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_a  <= '0;
            dp_b  <= '0;
            dp_op <= '0;
            ptr   <= '0;
        end else if (xfer) begin
            dp_a  <= a_arr[gidx];
            dp_b  <= b_arr[gidx];
            dp_op <= op_arr[gidx];
            ptr   <= (gidx == IDW'(NREQ - 1)) ? '0 : gidx + 1'b1;
        end
    end

    // Stage 0 lines up with the dp_* registers; stage LAT with dp_y.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k <= LAT; k++) tag_pipe[k] <= '0;
        end else begin
            tag_pipe[0] <= '{valid: xfer, id: IDMAX_W'(gidx)};
            for (int k = 1; k <= LAT; k++) tag_pipe[k] <= tag_pipe[k-1];
        end
    end

    assign rsp_valid = tag_pipe[LAT].valid;
    assign rsp_id    = tag_pipe[LAT].id[IDW-1:0];
    assign rsp_y     = rsp_valid ? dp_y  : '0;
    assign rsp_co    = rsp_valid ? dp_co : 1'b0;

    wire unused_tag_id = ^tag_pipe[LAT].id;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 inflight <= '0;
        else if (xfer && !rsp_valid) inflight <= inflight + 1'b1;
        else if (!xfer && rsp_valid) inflight <= inflight - 1'b1;
    end

    assign idle = (inflight == '0);
endmodule
